conv_seq_ctrl: RTL and testbench

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

---
 rtl/conv_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_seq_ctrl.sv
// Sequential 8x8 linear convolution engine: loads x then h over a valid/ready
// beat stream, computes y[k] with one shared multiplier, and emits each result.
module conv_seq_ctrl #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 4,
  localparam int unsigned AW = 2*W + $clog2(N),
  localparam int unsigned KW = $clog2(2*N - 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [AW-1:0] out_full,
  output logic [KW-1:0] out_idx,
  output logic          busy,
  output logic          done
);

  localparam int unsigned CW = $clog2(2*N);
  localparam int unsigned IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, LOAD, MAC, EMIT} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [KW-1:0] k, k_n;
  logic [IW-1:0] i, i_n;
  logic          drain, drain_n;
  logic [AW-1:0] acc, acc_n;
  logic [2*W-1:0] prod, prod_n;

  logic          in_ready_n, out_valid_n, busy_n, done_n;
  logic [W-1:0]  out_data_n;
  logic [AW-1:0] out_full_n;
  logic [KW-1:0] out_idx_n;

  logic [W-1:0]  x_mem [N];
  logic [W-1:0]  h_mem [N];
  logic          wr_en;
  logic          wr_is_h;
  logic [IW-1:0] wr_idx;

  logic [KW:0]    diff;
  logic           term_ok;
  logic [IW-1:0]  hidx;
  logic [2*W-1:0] mul;
  logic [AW-1:0]  acc_sum;

  // h index for the current term; out-of-range terms contribute zero
  assign diff    = {1'b0, k} - (KW+1)'(i);
  assign term_ok = !diff[KW] && (diff < (KW+1)'(N));
  assign hidx    = IW'(diff);
  assign mul     = (2*W)'(x_mem[i]) * (2*W)'(h_mem[hidx]);
  assign acc_sum = acc + AW'(prod);

  assign wr_is_h = (cnt >= CW'(N));
  assign wr_idx  = wr_is_h ? IW'(cnt - CW'(N)) : IW'(cnt);

  // Operand storage survives reset and clear; only a new load overwrites it
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_is_h) h_mem[wr_idx] <= in_data;
      else         x_mem[wr_idx] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      k         <= '0;
      i         <= '0;
      drain     <= 1'b0;
      acc       <= '0;
      prod      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_full  <= '0;
      out_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      k         <= k_n;
      i         <= i_n;
      drain     <= drain_n;
      acc       <= acc_n;
      prod      <= prod_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      out_full  <= out_full_n;
      out_idx   <= out_idx_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Product is registered, so a final drain cycle folds the i=N-1 term in
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    k_n         = k;
    i_n         = i;
    drain_n     = drain;
    acc_n       = acc;
    prod_n      = '0;
    wr_en       = 1'b0;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    out_full_n  = out_full;
    out_idx_n   = out_idx;
    done_n      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = LOAD;
          cnt_n   = '0;
          k_n     = '0;
          i_n     = '0;
          drain_n = 1'b0;
          acc_n   = '0;
        end
      end
      LOAD: begin
        if (in_valid && in_ready) begin
          wr_en = 1'b1;
          cnt_n = cnt + CW'(1);
          if (cnt == CW'(2*N - 1)) begin
            state_n = MAC;
            k_n     = '0;
            i_n     = '0;
            drain_n = 1'b0;
            acc_n   = '0;
          end
        end
      end
      MAC: begin
        acc_n = acc_sum;
        if (!drain) begin
          prod_n = term_ok ? mul : '0;
          if (i == IW'(N - 1)) drain_n = 1'b1;
          else                 i_n     = i + IW'(1);
        end else begin
          state_n     = EMIT;
          drain_n     = 1'b0;
          out_valid_n = 1'b1;
          out_full_n  = acc_sum;
          out_data_n  = W'(acc_sum);
          out_idx_n   = k;
        end
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          i_n         = '0;
          acc_n       = '0;
          if (k == KW'(2*N - 2)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            k_n     = k + KW'(1);
            state_n = MAC;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (clear) begin
      state_n     = IDLE;
      cnt_n       = '0;
      k_n         = '0;
      i_n         = '0;
      drain_n     = 1'b0;
      acc_n       = '0;
      prod_n      = '0;
      wr_en       = 1'b0;
      done_n      = 1'b0;
      out_valid_n = 1'b0;
      out_data_n  = '0;
      out_full_n  = '0;
      out_idx_n   = '0;
    end

    in_ready_n = (state_n == LOAD);
    busy_n     = (state_n != IDLE);
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: table of operand/result vectors plus
// hand-written reset, clear and backpressure sequences.
module tb_conv_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_data;
  logic [10:0] out_full;
  logic [3:0]  out_idx;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_full(out_full), .out_idx(out_idx), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [7:0][3:0]   x;
    logic [7:0][3:0]   h;
    logic [14:0][10:0] y;
    logic [3:0]        stall_k;   // 15 = no stall
    logic              gaps;
    logic              noise;
    logic              hold_ready;
  } vec_t;

  vec_t tbl [4];

  int ya[15] = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1};
  int yb[15] = '{225, 450, 675, 900, 1125, 1350, 1575, 1800,
                 1575, 1350, 1125, 900, 675, 450, 225};
  int yc[15] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0};
  int yd[15] = '{2, 4, 6, 8, 10, 12, 14, 17, 2, 3, 4, 5, 6, 7, 8};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0][3:0] x, input logic [7:0][3:0] h,
                      input logic gaps, output int acc_cyc);
    logic ok;
    ok = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("in_ready_after_start", 32'(in_ready), 1);
    chk("busy_after_start", 32'(busy), 1);
    for (int b = 0; b < 16; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 4'($urandom_range(0, 15));
        tick();
      end
      if (!in_ready) ok = 1'b0;
      in_valid = 1'b1;
      in_data  = (b < 8) ? x[b] : h[b-8];
      tick();
    end
    acc_cyc  = cyc;
    in_valid = 1'b0;
    chk("in_ready_during_load", 32'(ok), 1);
    chk("in_ready_after_load", 32'(in_ready), 0);
  endtask

  task automatic run_out(input vec_t v, input int last_k, input int acc_cyc_in);
    int          ac;
    int          n;
    logic        stable;
    logic [10:0] cap_full;
    logic [3:0]  cap_data;
    logic [3:0]  cap_idx;
    ac = acc_cyc_in;
    if (v.hold_ready) out_ready = 1'b1;
    for (int k = 0; k <= last_k; k++) begin
      n = 0;
      if (v.noise) begin
        start    = (k < 14);
        in_valid = (k < 14);
        in_data  = 4'hF;
      end
      while (!out_valid && n < 40) begin
        tick();
        n++;
      end
      if (!out_valid) begin
        chk($sformatf("out_valid_timeout[%0d]", k), 0, 1);
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        return;
      end
      chk($sformatf("latency[%0d]", k), 32'(cyc - ac), 9);
      chk($sformatf("out_full[%0d]", k), 32'(out_full), 32'(v.y[k]));
      chk($sformatf("out_data[%0d]", k), 32'(out_data), 32'(v.y[k][3:0]));
      chk($sformatf("out_idx[%0d]", k), 32'(out_idx), 32'(k));
      chk($sformatf("in_ready_emit[%0d]", k), 32'(in_ready), 0);
      if (k == int'(v.stall_k)) begin
        cap_full = out_full; cap_data = out_data; cap_idx = out_idx;
        stable = 1'b1;
        repeat (5) begin
          tick();
          if (!out_valid || out_full !== cap_full || out_data !== cap_data ||
              out_idx !== cap_idx || in_ready !== 1'b0) stable = 1'b0;
        end
        chk($sformatf("stall_hold[%0d]", k), 32'(stable), 1);
      end
      out_ready = 1'b1;
      tick();
      ac = cyc;
      if (!v.hold_ready) out_ready = 1'b0;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (last_k == 14) begin
      chk("done_pulse", 32'(done), 1);
      chk("busy_after_done", 32'(busy), 0);
      tick();
      chk("done_one_cycle", 32'(done), 0);
    end
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"},  32'(out_data), 0);
    chk({tag, "_out_full"},  32'(out_full), 0);
    chk({tag, "_out_idx"},   32'(out_idx), 0);
    chk({tag, "_busy"},      32'(busy), 0);
    chk({tag, "_done"},      32'(done), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ac;
    int n;

    tbl[0] = '0; tbl[0].x = 32'h1111_1111; tbl[0].h = 32'h1111_1111;
    tbl[0].stall_k = 4'd15; tbl[0].hold_ready = 1'b1;
    tbl[1] = '0; tbl[1].x = 32'hFFFF_FFFF; tbl[1].h = 32'hFFFF_FFFF;
    tbl[1].stall_k = 4'd15;
    tbl[2] = '0; tbl[2].x = 32'h0000_0001; tbl[2].h = 32'h8765_4321;
    tbl[2].stall_k = 4'd3; tbl[2].gaps = 1'b1;
    tbl[3] = '0; tbl[3].x = 32'h1000_0002; tbl[3].h = 32'h8765_4321;
    tbl[3].stall_k = 4'd15; tbl[3].noise = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tbl[0].y[k] = 11'(ya[k]);
      tbl[1].y[k] = 11'(yb[k]);
      tbl[2].y[k] = 11'(yc[k]);
      tbl[3].y[k] = 11'(yd[k]);
    end

    #2;
    chk_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 0);

    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    chk("clear_beats_start_busy", 32'(busy), 0);
    chk("clear_beats_start_in_ready", 32'(in_ready), 0);

    for (int v = 0; v < 4; v++) begin
      load(tbl[v].x, tbl[v].h, tbl[v].gaps, ac);
      run_out(tbl[v], 14, ac);
      tick();
    end

    // Asynchronous reset while computing y[6]
    load(tbl[1].x, tbl[1].h, 1'b0, ac);
    run_out(tbl[1], 5, ac);
    repeat (3) tick();
    chk("mac_busy_before_reset", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("midjob_reset");
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'h5;
    repeat (3) tick();
    chk("no_start_busy", 32'(busy), 0);
    chk("no_start_in_ready", 32'(in_ready), 0);
    in_valid = 1'b0;
    load(tbl[3].x, tbl[3].h, 1'b0, ac);
    run_out(tbl[3], 14, ac);
    tick();

    // Clear while y[3] is presented
    load(tbl[2].x, tbl[2].h, 1'b0, ac);
    run_out(tbl[2], 2, ac);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("emit_before_clear", 32'(out_valid), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_reset_vals("clear_emit");
    tick();
    chk("clear_no_done", 32'(done), 0);

    load(tbl[0].x, tbl[0].h, 1'b0, ac);
    run_out(tbl[0], 14, ac);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
